// File: rtl/hyper_trans_ctrl.sv
// HyperBus transaction sequencer: CA beats, initial latency, data phase, CS timing.
// Optional HYPER_DOUBLE_LAT_EN doubles the latency when RWDS is high in CA beat 2.
module hyper_trans_ctrl #(
    parameter int LEN_W = 16,
    parameter int LAT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             trans_valid_i,
    output logic             trans_ready_o,
    input  logic             trans_rw_i,
    input  logic             trans_addr_space_i,
    input  logic             trans_burst_type_i,
    input  logic [31:0]      trans_addr_i,
    input  logic [LEN_W-1:0] trans_len_i,
    input  logic [LAT_W-1:0] latency_i,
    input  logic             rwds_i,
    input  logic             data_stall_i,
    output logic             cs_no,
    output logic [15:0]      ca_o,
    output logic             ca_valid_o,
    output logic             data_en_o,
    output logic             data_last_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CA,
        S_LAT,
        S_DATA,
        S_END
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         beat_q, beat_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [LAT_W:0]     cnt_q, cnt_d;
    logic [LEN_W-1:0]   words_q, words_d;
    logic [47:0]        ca_q, ca_d;
    logic [LAT_W:0]     lat_load;
    logic               skip_lat;

`ifdef HYPER_DOUBLE_LAT_EN
    assign lat_load = rwds_i ? {lat_q, 1'b0} : {1'b0, lat_q};
`else
    logic unused_rwds;
    assign unused_rwds = rwds_i;
    assign lat_load    = {1'b0, lat_q};
`endif

    // Register writes carry no latency on the bus.
    assign skip_lat = (~ca_q[47] & ca_q[46]) | (lat_q == '0);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        lat_d   = lat_q;
        cnt_d   = cnt_q;
        words_d = words_q;
        ca_d    = ca_q;
        unique case (state_q)
            S_IDLE: begin
                if (trans_valid_i) begin
                    ca_d = {trans_rw_i, trans_addr_space_i,
                            trans_burst_type_i, trans_addr_i[31:3],
                            13'b0, trans_addr_i[2:0]};
                    lat_d   = latency_i;
                    words_d = (trans_len_i == '0) ? LEN_W'(1)
                                                  : trans_len_i;
                    beat_d  = 2'd0;
                    state_d = S_CA;
                end
            end
            S_CA: begin
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd2) begin
                    beat_d  = 2'd0;
                    cnt_d   = lat_load;
                    state_d = skip_lat ? S_DATA : S_LAT;
                end
            end
            S_LAT: begin
                if (cnt_q <= (LAT_W+1)'(1)) begin
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - (LAT_W+1)'(1);
                end
            end
            S_DATA: begin
                if (!data_stall_i) begin
                    if (words_q == LEN_W'(1)) begin
                        state_d = S_END;
                    end else begin
                        words_d = words_q - LEN_W'(1);
                    end
                end
            end
            S_END: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            lat_q   <= '0;
            cnt_q   <= '0;
            words_q <= '0;
            ca_q    <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
            cnt_q   <= cnt_d;
            words_q <= words_d;
            ca_q    <= ca_d;
        end
    end

    always_comb begin
        ca_o = 16'h0;
        if (state_q == S_CA) begin
            unique case (beat_q)
                2'd0:    ca_o = ca_q[47:32];
                2'd1:    ca_o = ca_q[31:16];
                default: ca_o = ca_q[15:0];
            endcase
        end
    end

    // Chip select drops out as soon as reset is seen.
    assign cs_no = rst_i | (state_q == S_IDLE) | (state_q == S_END);
    assign trans_ready_o = ~rst_i & (state_q == S_IDLE);
    assign ca_valid_o    = (state_q == S_CA);
    assign data_en_o     = (state_q == S_DATA) & ~data_stall_i;
    assign data_last_o   = data_en_o & (words_q == LEN_W'(1));
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_END);

endmodule

// File: tb/tb_hyper_trans_ctrl.sv
// Directed bench for hyper_trans_ctrl: CA packing, latency, data phase,
// stalls, mid-transaction reset, optional double latency.
module tb_hyper_trans_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        trans_valid_i;
    logic        trans_ready_o;
    logic        trans_rw_i;
    logic        trans_addr_space_i;
    logic        trans_burst_type_i;
    logic [31:0] trans_addr_i;
    logic [15:0] trans_len_i;
    logic [3:0]  latency_i;
    logic        rwds_i;
    logic        data_stall_i;
    logic        cs_no;
    logic [15:0] ca_o;
    logic        ca_valid_o;
    logic        data_en_o;
    logic        data_last_o;
    logic        busy_o;
    logic        done_o;

    int total = 0;
    int bad   = 0;

    logic [15:0] ca_a   [0:39];
    logic        cs_a   [0:39];
    logic        cav_a  [0:39];
    logic        den_a  [0:39];
    logic        dl_a   [0:39];
    logic        done_a [0:39];
    logic        busy_a [0:39];
    logic [39:0] stall_mask;
    logic [39:0] rwds_mask;

    int nen, fen, lidx, nlast, didx;

    always #5 clk_i = ~clk_i;

    hyper_trans_ctrl dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .trans_valid_i      (trans_valid_i),
        .trans_ready_o      (trans_ready_o),
        .trans_rw_i         (trans_rw_i),
        .trans_addr_space_i (trans_addr_space_i),
        .trans_burst_type_i (trans_burst_type_i),
        .trans_addr_i       (trans_addr_i),
        .trans_len_i        (trans_len_i),
        .latency_i          (latency_i),
        .rwds_i             (rwds_i),
        .data_stall_i       (data_stall_i),
        .cs_no              (cs_no),
        .ca_o               (ca_o),
        .ca_valid_o         (ca_valid_o),
        .data_en_o          (data_en_o),
        .data_last_o        (data_last_o),
        .busy_o             (busy_o),
        .done_o             (done_o)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic start(input logic rw, input logic sp, input logic bt,
                         input logic [31:0] addr, input logic [15:0] len,
                         input logic [3:0] lat);
        @(posedge clk_i);
        #1;
        trans_valid_i      = 1'b1;
        trans_rw_i         = rw;
        trans_addr_space_i = sp;
        trans_burst_type_i = bt;
        trans_addr_i       = addr;
        trans_len_i        = len;
        latency_i          = lat;
        @(negedge clk_i);
        check("ready_t0", 32'(trans_ready_o), 32'd1);
    endtask

    // Index k is cycle Tk relative to the handshake cycle T0.
    task automatic capture(input int n);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk_i);
            #1;
            trans_valid_i = 1'b0;
            data_stall_i  = stall_mask[k];
            rwds_i        = rwds_mask[k];
            @(negedge clk_i);
            ca_a[k]   = ca_o;
            cs_a[k]   = cs_no;
            cav_a[k]  = ca_valid_o;
            den_a[k]  = data_en_o;
            dl_a[k]   = data_last_o;
            done_a[k] = done_o;
            busy_a[k] = busy_o;
        end
        data_stall_i = 1'b0;
        rwds_i       = 1'b0;
    endtask

    task automatic analyze(input int n);
        nen = 0; fen = -1; lidx = -1; nlast = 0; didx = -1;
        for (int k = 1; k <= n; k++) begin
            if (den_a[k]) begin
                nen++;
                if (fen < 0) fen = k;
            end
            if (dl_a[k]) begin
                nlast++;
                lidx = k;
            end
            if (done_a[k] && didx < 0) didx = k;
        end
    endtask

    initial begin
        rst_i = 1'b1;
        trans_valid_i = 1'b0;
        trans_rw_i = 1'b0;
        trans_addr_space_i = 1'b0;
        trans_burst_type_i = 1'b0;
        trans_addr_i = '0;
        trans_len_i = '0;
        latency_i = '0;
        rwds_i = 1'b0;
        data_stall_i = 1'b0;
        stall_mask = '0;
        rwds_mask = '0;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_ready", 32'(trans_ready_o), 32'd0);
        check("rst_cs",    32'(cs_no),         32'd1);
        check("rst_busy",  32'(busy_o),        32'd0);
        check("rst_cav",   32'(ca_valid_o),    32'd0);
        check("rst_done",  32'(done_o),        32'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("idle_ready", 32'(trans_ready_o), 32'd1);

        // read, memory, linear, len 4, latency 6
        start(1'b1, 1'b0, 1'b1, 32'h0000_1235, 16'd4, 4'd6);
        capture(16);
        check("t1_ca0",  32'(ca_a[1]), 32'hA000);
        check("t1_ca1",  32'(ca_a[2]), 32'h0246);
        check("t1_ca2",  32'(ca_a[3]), 32'h0005);
        check("t1_cav",  32'(cav_a[2]), 32'd1);
        check("t1_cav4", 32'(cav_a[4]), 32'd0);
        check("t1_cs1",  32'(cs_a[1]), 32'd0);
        check("t1_cs4",  32'(cs_a[4]), 32'd0);
        check("t1_busy", 32'(busy_a[5]), 32'd1);
        analyze(16);
        check("t1_nen",  32'(nen),   32'd4);
        check("t1_fen",  32'(fen),   32'd10);
        check("t1_last", 32'(lidx),  32'd13);
        check("t1_nl",   32'(nlast), 32'd1);
        check("t1_done", 32'(didx),  32'd14);
        check("t1_cs14", 32'(cs_a[14]), 32'd1);
        check("t1_idle", 32'(busy_a[15]), 32'd0);

        // register write, len 1, latency ignored
        start(1'b0, 1'b1, 1'b1, 32'h0000_0800, 16'd1, 4'd6);
        capture(8);
        check("t2_ca0", 32'(ca_a[1]), 32'h6000);
        check("t2_ca1", 32'(ca_a[2]), 32'h0100);
        check("t2_ca2", 32'(ca_a[3]), 32'h0000);
        analyze(8);
        check("t2_nen",  32'(nen),  32'd1);
        check("t2_fen",  32'(fen),  32'd4);
        check("t2_last", 32'(lidx), 32'd4);
        check("t2_done", 32'(didx), 32'd5);

        // read, len 0 treated as 1, latency 0
        start(1'b1, 1'b0, 1'b0, 32'h0000_0010, 16'd0, 4'd0);
        capture(8);
        analyze(8);
        check("t3_nen",  32'(nen),  32'd1);
        check("t3_fen",  32'(fen),  32'd4);
        check("t3_last", 32'(lidx), 32'd4);
        check("t3_done", 32'(didx), 32'd5);

        // read, len 3, latency 2, stall in T7 and T8
        stall_mask = '0;
        stall_mask[7] = 1'b1;
        stall_mask[8] = 1'b1;
        start(1'b1, 1'b0, 1'b1, 32'h0000_0040, 16'd3, 4'd2);
        capture(14);
        stall_mask = '0;
        analyze(14);
        check("t4_nen",   32'(nen),   32'd3);
        check("t4_fen",   32'(fen),   32'd6);
        check("t4_den7",  32'(den_a[7]), 32'd0);
        check("t4_cs8",   32'(cs_a[8]),  32'd0);
        check("t4_last",  32'(lidx),  32'd10);
        check("t4_nl",    32'(nlast), 32'd1);
        check("t4_done",  32'(didx),  32'd11);

        // reset during LAT
        start(1'b1, 1'b0, 1'b1, 32'h0000_0100, 16'd2, 4'd6);
        capture(5);
        check("t5_inlat", 32'(busy_a[5]), 32'd1);
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("t5_cs",    32'(cs_no),  32'd1);
        check("t5_busy",  32'(busy_o), 32'd0);
        check("t5_done",  32'(done_o), 32'd0);
        check("t5_rdy_r", 32'(trans_ready_o), 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("t5_ready", 32'(trans_ready_o), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            check("t5_nodone", 32'(done_o), 32'd0);
        end

        // rwds high in T3
        rwds_mask = '0;
        rwds_mask[3] = 1'b1;
        start(1'b1, 1'b0, 1'b1, 32'h0000_0200, 16'd1, 4'd6);
        capture(22);
        analyze(22);
`ifdef HYPER_DOUBLE_LAT_EN
        check("t6_fen",  32'(fen),  32'd16);
        check("t6_done", 32'(didx), 32'd17);
`else
        check("t6_fen",  32'(fen),  32'd10);
        check("t6_done", 32'(didx), 32'd11);
`endif

        // rwds low in T3
        rwds_mask = '0;
        start(1'b1, 1'b0, 1'b1, 32'h0000_0200, 16'd1, 4'd6);
        capture(14);
        analyze(14);
        check("t7_fen",  32'(fen),  32'd10);
        check("t7_done", 32'(didx), 32'd11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
